// File: rtl/intersect_checker.sv
// Checks an a/b reference sequence plus a c/d companion ordering per trigger; verdict one cycle after end sample.
// No backpressure: a trigger while busy is dropped and flagged by a one-cycle missed pulse.
module intersect_checker #(
    parameter int A_REP    = 4,
    parameter int GAP      = 2,
    parameter int B_REP    = 2,
    parameter int C_CNT    = 2,
    parameter int D_CNT    = 2,
    parameter int LEAD_LOW = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             d,
    output logic             busy,
    output logic             pass,
    output logic             fail,
    output logic [1:0]       fail_code,
    output logic             missed,
    output logic [CNT_W-1:0] pass_count,
    output logic [CNT_W-1:0] fail_count
);
    // 10 bits covers the longest attempt (764 samples) and C_CNT+1 / D_CNT thresholds.
    localparam int CW = 10;
    localparam logic [CW-1:0] A_END   = CW'(A_REP - 1);
    localparam logic [CW-1:0] B_START = CW'(A_REP - 1 + GAP);
    localparam logic [CW-1:0] E_OFF   = CW'(A_REP + GAP + B_REP - 2);
    localparam logic [CW-1:0] C_K     = CW'(C_CNT);
    localparam logic [CW-1:0] C_K1    = CW'(C_CNT + 1);
    localparam logic [CW-1:0] D_K     = CW'(D_CNT);

    typedef enum logic [1:0] {IDLE, REF_A, REF_GAP, REF_B} state_t;

    state_t           state_q, state_d;
    logic             a_prev_q;
    logic [CW-1:0]    off_q, off_d;
    logic [CW-1:0]    c_cnt_q, c_cnt_d;
    logic [CW-1:0]    d_all_q, d_all_d;
    logic [CW-1:0]    d_late_q, d_late_d;
    logic             lead_bad_q, lead_bad_d;
    logic             pass_q, pass_d, fail_q, fail_d, missed_q, missed_d;
    logic [1:0]       code_q, code_d;
    logic [CNT_W-1:0] pcnt_q, pcnt_d, fcnt_q, fcnt_d;

    logic             trig, ref_bad, comp_ok;
    logic [CW-1:0]    c_new, d_all_new, d_late_new, d_late_eff;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v, input logic en);
        return (en && v != '1) ? v + CW'(1) : v;
    endfunction

    // Offset k is the sample index relative to the trigger; the state follows from it.
    function automatic state_t state_at(input logic [CW-1:0] k);
        if (k >= B_START) return REF_B;
        return (k <= A_END) ? REF_A : REF_GAP;
    endfunction

    assign trig       = a && !a_prev_q;
    assign ref_bad    = (state_q == REF_A && !a) || (state_q == REF_B && !b);
    assign c_new      = sat_inc(c_cnt_q, c);
    assign d_all_new  = sat_inc(d_all_q, d && (c_cnt_q >= C_K));
    assign d_late_new = sat_inc(d_late_q, d && (c_new >= C_K1));
    // Without a (C_CNT+1)-th c by the end sample, only d at that sample counts as late.
    assign d_late_eff = (c_new >= C_K1) ? d_late_new : {{(CW-1){1'b0}}, d};
    assign comp_ok    = !lead_bad_q && (c_cnt_q >= C_K) && (d_all_new >= D_K) && (d_late_eff <= D_K);

    always_comb begin
        state_d    = state_q;
        off_d      = off_q;
        c_cnt_d    = c_cnt_q;
        d_all_d    = d_all_q;
        d_late_d   = d_late_q;
        lead_bad_d = lead_bad_q;
        pass_d     = 1'b0;
        fail_d     = 1'b0;
        code_d     = 2'b00;
        missed_d   = 1'b0;
        pcnt_d     = pcnt_q;
        fcnt_d     = fcnt_q;
        if (state_q == IDLE) begin
            if (trig) begin
                state_d    = state_at(CW'(1));
                off_d      = CW'(1);
                c_cnt_d    = {{(CW-1){1'b0}}, (LEAD_LOW == 0) && c};
                d_all_d    = '0;
                d_late_d   = '0;
                lead_bad_d = (LEAD_LOW != 0) && c;
            end
        end else begin
            missed_d = trig;
            if (ref_bad) begin
                state_d = IDLE;
                fail_d  = 1'b1;
                code_d  = 2'b01;
            end else if (off_q == E_OFF) begin
                state_d = IDLE;
                pass_d  = comp_ok;
                fail_d  = !comp_ok;
                code_d  = comp_ok ? 2'b00 : 2'b10;
            end else begin
                off_d    = off_q + CW'(1);
                state_d  = state_at(off_q + CW'(1));
                c_cnt_d  = c_new;
                d_all_d  = d_all_new;
                d_late_d = d_late_new;
            end
        end
        if (pass_d && pcnt_q != '1) pcnt_d = pcnt_q + CNT_W'(1);
        if (fail_d && fcnt_q != '1) fcnt_d = fcnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            a_prev_q   <= 1'b0;
            off_q      <= '0;
            c_cnt_q    <= '0;
            d_all_q    <= '0;
            d_late_q   <= '0;
            lead_bad_q <= 1'b0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            code_q     <= 2'b00;
            missed_q   <= 1'b0;
            pcnt_q     <= '0;
            fcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            a_prev_q   <= a;
            off_q      <= off_d;
            c_cnt_q    <= c_cnt_d;
            d_all_q    <= d_all_d;
            d_late_q   <= d_late_d;
            lead_bad_q <= lead_bad_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            code_q     <= code_d;
            missed_q   <= missed_d;
            pcnt_q     <= pcnt_d;
            fcnt_q     <= fcnt_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign pass       = pass_q;
    assign fail       = fail_q;
    assign fail_code  = code_q;
    assign missed     = missed_q;
    assign pass_count = pcnt_q;
    assign fail_count = fcnt_q;
endmodule

// File: tb/tb_intersect_checker.sv
// Scoreboard bench for intersect_checker: verdicts and missed pulses are queued when stimulus is driven.
// Statistics counters are narrowed to 2 bits so saturation is reachable.
module tb_intersect_checker;
    logic       clk, rst_n, a, b, c, d;
    logic       busy, pass, fail, missed;
    logic [1:0] fail_code;
    logic [1:0] pass_count, fail_count;

    typedef struct {
        string      tag;
        logic       exp_pass;
        logic [1:0] code;
        int         at;
    } exp_t;

    exp_t exp_q[$];
    int   miss_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   exp_pc   = 0;
    int   exp_fc   = 0;
    logic busy_log [16];

    intersect_checker #(.CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d),
        .busy(busy), .pass(pass), .fail(fail), .fail_code(fail_code), .missed(missed),
        .pass_count(pass_count), .fail_count(fail_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Monitor: pops expectations when the DUT reports, and flags overdue ones.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0 && exp_q[0].at < cyc) begin
            chk({exp_q[0].tag, "_late"}, cyc, exp_q[0].at);
            void'(exp_q.pop_front());
        end
        if (pass || fail) begin
            chk("one_hot", pass && fail, 0);
            if (exp_q.size() == 0) begin
                chk("unexp_verdict", pass || fail, 0);
            end else begin
                e = exp_q.pop_front();
                chk({e.tag, "_pass"}, pass, e.exp_pass);
                chk({e.tag, "_code"}, fail_code, e.exp_pass ? 2'b00 : e.code);
                chk({e.tag, "_cyc"}, cyc, e.at);
                if (e.exp_pass) exp_pc = (exp_pc == 3) ? 3 : exp_pc + 1;
                else            exp_fc = (exp_fc == 3) ? 3 : exp_fc + 1;
            end
        end else if (fail_code != 2'b00) begin
            chk("code_idle", fail_code, 0);
        end
        if (missed) begin
            if (miss_q.size() == 0) chk("unexp_missed", missed, 0);
            else                    chk("missed_cyc", cyc, miss_q.pop_front());
        end
    end

    task automatic idle(input int n);
        a = 0; b = 0; c = 0; d = 0;
        repeat (n) @(negedge clk);
    endtask

    // Bit k of each vector is applied at sample T+k; called on a falling edge.
    task automatic drive_seq(input int n, input logic [15:0] av, bv, cv, dv);
        logic [15:0] va, vb, vc, vd;
        va = av; vb = bv; vc = cv; vd = dv;
        for (int k = 0; k < n; k++) begin
            a = va[k]; b = vb[k]; c = vc[k]; d = vd[k];
            @(posedge clk);
            @(negedge clk);
            busy_log[k] = busy;
        end
        a = 0; b = 0; c = 0; d = 0;
    endtask

    task automatic push_exp(input string tag, input logic p, input logic [1:0] code, input int at);
        exp_t e;
        e.tag = tag; e.exp_pass = p; e.code = code; e.at = at;
        exp_q.push_back(e);
    endtask

    task automatic run1(input string tag, input logic p, input logic [1:0] code, input int off,
                        input logic [15:0] av, bv, cv, dv);
        push_exp(tag, p, code, cyc + 1 + off);
        drive_seq(8, av, bv, cv, dv);
        idle(3);
    endtask

    initial begin
        rst_n = 0; a = 0; b = 0; c = 0; d = 0;
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_pass", pass, 0);
        chk("rst_fail", fail, 0);
        chk("rst_missed", missed, 0);
        chk("rst_code", fail_code, 0);
        chk("rst_pcnt", pass_count, 0);
        chk("rst_fcnt", fail_count, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1;
        idle(2);

        // a T..T+3, b T+5..T+6, c T+1,T+3, d T+4,T+6
        run1("base", 1, 2'b00, 6, 16'h000F, 16'h0060, 16'h000A, 16'h0050);
        chk("pcnt_after_base", pass_count, exp_pc);
        run1("b_drop_end", 0, 2'b01, 6, 16'h000F, 16'h0020, 16'h000A, 16'h0050);
        run1("a_drop", 0, 2'b01, 2, 16'h0003, 16'h0060, 16'h000A, 16'h0050);
        chk("a_drop_busy0", busy_log[0], 1);
        chk("a_drop_busy1", busy_log[1], 1);
        chk("a_drop_busy2", busy_log[2], 0);
        run1("c_short", 0, 2'b10, 6, 16'h000F, 16'h0060, 16'h0002, 16'h0050);
        run1("d_late3", 0, 2'b10, 6, 16'h000F, 16'h0060, 16'h001A, 16'h0070);
        run1("lead_c", 0, 2'b10, 6, 16'h000F, 16'h0060, 16'h000B, 16'h0050);
        miss_q.push_back(cyc + 1 + 5);
        run1("miss_t5", 1, 2'b00, 6, 16'h002F, 16'h0060, 16'h000A, 16'h0050);
        miss_q.push_back(cyc + 1 + 6);
        run1("miss_at_e", 1, 2'b00, 6, 16'h004F, 16'h0060, 16'h000A, 16'h0050);

        // Second trigger at E+1 must be accepted.
        push_exp("b2b_1", 1, 2'b00, cyc + 1 + 6);
        push_exp("b2b_2", 1, 2'b00, cyc + 1 + 13);
        drive_seq(15, 16'h078F, 16'h3060, 16'h050A, 16'h2850);
        idle(3);
        chk("pcnt_sat", pass_count, exp_pc);
        chk("fcnt_sat", fail_count, exp_fc);
        chk("pending_before_rst", exp_q.size(), 0);

        // Reset in the middle of an attempt: no verdict, immediate idle.
        drive_seq(5, 16'h000F, 16'h0000, 16'h0000, 16'h0000);
        chk("mid_busy", busy, 1);
        rst_n = 0;
        exp_pc = 0;
        exp_fc = 0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_pass", pass, 0);
        chk("mid_rst_fail", fail, 0);
        @(negedge clk); @(negedge clk);
        chk("mid_rst_pcnt", pass_count, 0);
        chk("mid_rst_fcnt", fail_count, 0);
        rst_n = 1;
        run1("first_after_rst", 1, 2'b00, 6, 16'h000F, 16'h0060, 16'h000A, 16'h0050);
        chk("pcnt_after_rst", pass_count, exp_pc);
        chk("fcnt_after_rst", fail_count, exp_fc);
        chk("pending_verdicts", exp_q.size(), 0);
        chk("pending_missed", miss_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/intersect_checker.md
INTERSECT_CHECKER -- requirements
Module: intersect_checker

Interface
REQ-001 Parameter A_REP, default 4: consecutive cycles a must be high, starting at the trigger cycle (range 1..255).
REQ-002 Parameter GAP, default 2: cycle delay from the last a cycle to the first b cycle (range 1..255).
REQ-003 Parameter B_REP, default 2: consecutive cycles b must be high (range 1..255).
REQ-004 Parameter C_CNT, default 2: number of non-consecutive c occurrences required (range 1..255).
REQ-005 Parameter D_CNT, default 2: number of non-consecutive d occurrences required (range 1..255).
REQ-006 Parameter LEAD_LOW, default 1: 1 = c must be 0 at the trigger cycle and c counting starts at T+1; 0 = c counting starts at T.
REQ-007 Parameter CNT_W, default 16: width of the pass/fail statistics counters.
REQ-008 clk  in  1  sole clock; all sampling on the rising edge.
REQ-009 rst_n  in  1  reset, asynchronous, active-low.
REQ-010 a, b, c, d  in  1 each  monitored signals.
REQ-011 busy  out  1  an attempt is in progress.
REQ-012 pass  out  1  one-cycle pulse: the attempt matched.
REQ-013 fail  out  1  one-cycle pulse: the attempt did not match.
REQ-014 fail_code  out  2  valid while fail=1: 01 = reference mismatch, 10 = companion mismatch; 00 otherwise.
REQ-015 missed  out  1  one-cycle pulse: a trigger arrived while busy.
REQ-016 pass_count, fail_count  out  CNT_W each  saturating verdict totals.

Function
REQ-017 Trigger at sample T: a=1 and a_prev=0 while the FSM is in IDLE; a_prev is a register holding a from the previous sample.
REQ-018 End cycle: E = T + A_REP - 1 + GAP + B_REP - 1; all timing is in samples relative to T.
REQ-019 Reference sequence: a=1 on T..T+A_REP-1; b is don't-care until T+A_REP-1+GAP; b=1 on T+A_REP-1+GAP..E.
REQ-020 The FSM has states IDLE, REF_A, REF_GAP, REF_B, with transitions IDLE -> REF_A -> REF_GAP -> REF_B -> IDLE.
REQ-021 REF_GAP is traversed for GAP-1 samples; REF_GAP is skipped when GAP=1.
REQ-022 busy=1 in every state except IDLE.
REQ-023 A reference violation (a=0 in REF_A, or b=0 in REF_B) ends the attempt early: fail=1 with fail_code=01 on the next cycle, and the FSM returns to IDLE.
REQ-024 When LEAD_LOW=1 and c=1 at T, the companion is marked failed; the verdict is deferred to E.
REQ-025 Companion tracking: pK is the sample of the C_CNT-th c; pK1 is the sample of the (C_CNT+1)-th c.
REQ-026 d_all counts d over pK+1..E.
REQ-027 d_late counts d over pK1..E; if no pK1 occurs by E, d_late equals d at E.
REQ-028 Counters for REQ-026/027 are sized to hold the attempt length and saturate.
REQ-029 The companion matches iff pK exists with pK <= E-1, d_all >= D_CNT and d_late <= D_CNT.
REQ-030 At sample E with the reference intact: companion match gives pass=1; companion mismatch gives fail=1 with fail_code=10. The verdict is registered one cycle after E.
REQ-031 Exactly one of pass/fail pulses per accepted attempt.
REQ-032 Triggers are non-overlapping: a trigger sampled while busy (including sample E) produces missed=1 and is otherwise ignored.
REQ-033 A trigger at E+1 is accepted.
REQ-034 pass_count and fail_count increment with their pulse and hold at 2^CNT_W-1.

Reset
REQ-035 While rst_n=0: FSM=IDLE, a_prev=0, all internal counters 0, and busy, pass, fail, missed, fail_code, pass_count, fail_count all 0.
REQ-036 Reset mid-attempt discards the attempt with no verdict pulse.
REQ-037 After release of rst_n, a=1 at the first sample counts as a trigger.

Verification (defaults, so E=T+6)
REQ-038 Stimulus: a=1 on T..T+3; b=1 on T+5..T+6; c=0 at T, c=1 at T+1 and T+3; d=1 at T+4 and T+6 -> pass at T+7, pass_count=1.
REQ-039 Stimulus: as REQ-038 but b=0 at T+6 -> fail at T+7, fail_code=01.
REQ-040 Stimulus: a=0 at T+2 -> fail at T+3, fail_code=01, busy=0 at T+3.
REQ-041 Stimulus: as REQ-038 but c=1 only at T+1 -> fail at T+7, fail_code=10.
REQ-042 Stimulus: as REQ-038 plus c=1 at T+4 and d=1 at T+4, T+5, T+6 (d_late=3) -> fail at T+7, fail_code=10.
REQ-043 Stimulus: a falls then rises at T+5 -> missed=1 at T+6; rst_n=0 at T+5 in a fresh attempt -> busy=0 immediately and no pass/fail pulse.
